// File: rtl/ir_pkg.sv
// Shared types and constants for the saber IR frame decoder.
// Thresholds are expressed as multiples of a half protocol unit.
package ir_pkg;

    typedef enum logic [2:0] {
        RESYNC,
        IDLE,
        LEADER,
        LEADER_SPACE,
        BIT_MARK,
        BIT_SPACE,
        CHECK
    } ir_state_e;

    localparam int BLOCK_BIT   = 0;
    localparam int LUNGE_BIT   = 1;
    localparam int RELEASE_BIT = 2;
    localparam int PARITY_BIT  = 3;
    localparam int FRAME_BITS  = 4;

    localparam int HM_1  = 1;
    localparam int HM_3  = 3;
    localparam int HM_5  = 5;
    localparam int HM_6  = 6;
    localparam int HM_10 = 10;

    // Odd parity over all four bits, and at most one command set.
    function automatic logic frame_ok(input logic [FRAME_BITS-1:0] b);
        logic par_ok;
        logic excl_ok;
        par_ok  = b[PARITY_BIT] ==
                  ~(b[BLOCK_BIT] ^ b[LUNGE_BIT] ^ b[RELEASE_BIT]);
        excl_ok = !((b[BLOCK_BIT] & b[LUNGE_BIT]) |
                    (b[BLOCK_BIT] & b[RELEASE_BIT]) |
                    (b[LUNGE_BIT] & b[RELEASE_BIT]));
        return par_ok && excl_ok;
    endfunction

endpackage

// File: rtl/ir_input_filter.sv
// Two-flop synchronizer and 3-sample majority-hold glitch filter.
// Pulses of two samples or fewer never reach ir_f.
module ir_input_filter (
    input  logic clk_pixel_in,
    input  logic rst_n_in,
    input  logic ir_rx_in,
    output logic ir_f
);

    logic [1:0] sync;
    logic [2:0] h;

    always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sync <= '0;
            h    <= '0;
            ir_f <= 1'b0;
        end else begin
            sync <= {sync[0], ir_rx_in};
            h    <= {h[1:0], sync[1]};
            if (h == 3'b111)
                ir_f <= 1'b1;
            else if (h == 3'b000)
                ir_f <= 1'b0;
        end
    end

endmodule

// File: rtl/ir_saber_decoder.sv
// Pulse-width IR frame decoder: leader, four bit marks, parity and
// exclusivity check, producing held command levels and strobes.
module ir_saber_decoder
    import ir_pkg::*;
#(
    parameter int UNIT_CYCLES = 44550
) (
    input  logic clk_pixel_in,
    input  logic rst_n_in,
    input  logic ir_rx_in,
    output logic block_out,
    output logic lunge_out,
    output logic release_out,
    output logic valid_out,
    output logic frame_error_out
);

    localparam int H     = UNIT_CYCLES / 2;
    localparam int CNT_W = $clog2(10 * H + 1);

    localparam logic [CNT_W-1:0] T1   = CNT_W'(HM_1 * H);
    localparam logic [CNT_W-1:0] T3   = CNT_W'(HM_3 * H);
    localparam logic [CNT_W-1:0] T5   = CNT_W'(HM_5 * H);
    localparam logic [CNT_W-1:0] T6   = CNT_W'(HM_6 * H);
    localparam logic [CNT_W-1:0] T6M1 = CNT_W'(HM_6 * H - 1);
    localparam logic [CNT_W-1:0] T10  = CNT_W'(HM_10 * H);

    logic                  ir_f;
    logic                  ir_f_d;
    logic                  rise;
    logic                  fall;
    logic                  ir_edge;
    logic [CNT_W-1:0]      cnt;
    ir_state_e             state;
    ir_state_e             nxt;
    logic [FRAME_BITS-1:0] bits;
    logic [1:0]            bit_cnt;

    logic w_bit;
    logic w_one;
    logic w_lead;
    logic mark_to;
    logic space_to;
    logic fault;
    logic shift_en;
    logic accept;
    logic reject;

    ir_input_filter u_filter (
        .clk_pixel_in (clk_pixel_in),
        .rst_n_in     (rst_n_in),
        .ir_rx_in     (ir_rx_in),
        .ir_f         (ir_f)
    );

    assign rise    = ir_f & ~ir_f_d;
    assign fall    = ~ir_f & ir_f_d;
    assign ir_edge = rise | fall;

    // Short window serves zero marks and bit spaces; mid window
    // serves one marks and the leader space.
    assign w_bit    = (cnt >= T1) && (cnt < T3);
    assign w_one    = (cnt >= T3) && (cnt < T5);
    assign w_lead   = (cnt >= T6) && (cnt < T10);
    assign mark_to  = (cnt == T10);
    assign space_to = (cnt == T5);

    always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            ir_f_d <= 1'b0;
            cnt    <= '0;
        end else begin
            ir_f_d <= ir_f;
            if (ir_edge)
                cnt <= CNT_W'(1);
            else if (cnt != T10)
                cnt <= cnt + CNT_W'(1);
        end
    end

    always_comb begin
        fault = 1'b0;
        unique case (state)
            LEADER:       fault = (fall && !w_lead) || mark_to;
            LEADER_SPACE: fault = (rise && !w_one) || space_to;
            BIT_MARK:     fault = (fall && !(w_bit || w_one)) || mark_to;
            BIT_SPACE:    fault = (rise && !w_bit) || space_to;
            default:      fault = 1'b0;
        endcase
    end

    always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
        if (!rst_n_in)
            state <= RESYNC;
        else
            state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            RESYNC:
                if (!ir_f && !fall && cnt >= T6M1)
                    nxt = IDLE;
            IDLE:
                if (rise)
                    nxt = LEADER;
            LEADER:
                if (fault)
                    nxt = RESYNC;
                else if (fall)
                    nxt = LEADER_SPACE;
            LEADER_SPACE:
                if (fault)
                    nxt = RESYNC;
                else if (rise)
                    nxt = BIT_MARK;
            BIT_MARK:
                if (fault)
                    nxt = RESYNC;
                else if (fall)
                    nxt = (bit_cnt == 2'(FRAME_BITS - 1)) ? CHECK : BIT_SPACE;
            BIT_SPACE:
                if (fault)
                    nxt = RESYNC;
                else if (rise)
                    nxt = BIT_MARK;
            CHECK:
                nxt = IDLE;
            default:
                nxt = RESYNC;
        endcase
    end

    always_comb begin
        shift_en = (state == BIT_MARK) && fall && !fault;
        accept   = (state == CHECK) && frame_ok(bits);
        reject   = fault || ((state == CHECK) && !frame_ok(bits));
    end

    always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            bits    <= '0;
            bit_cnt <= '0;
        end else if (state == LEADER_SPACE) begin
            bit_cnt <= '0;
        end else if (shift_en) begin
            bits    <= {w_one, bits[FRAME_BITS-1:1]};
            bit_cnt <= bit_cnt + 2'd1;
        end
    end

    always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            block_out       <= 1'b0;
            lunge_out       <= 1'b0;
            release_out     <= 1'b0;
            valid_out       <= 1'b0;
            frame_error_out <= 1'b0;
        end else begin
            valid_out       <= accept;
            frame_error_out <= reject;
            if (accept) begin
                block_out   <= bits[BLOCK_BIT];
                lunge_out   <= bits[LUNGE_BIT];
                release_out <= bits[RELEASE_BIT];
            end
        end
    end

endmodule

// File: tb/tb_ir_saber_decoder.sv
// Directed bench for ir_saber_decoder with UNIT_CYCLES=16 (H=8).
// Expected timings are hand-derived from the raw line waveform.
module tb_ir_saber_decoder;

    localparam int UNIT = 16;

    logic clk = 1'b0;
    logic rst_n;
    logic ir_rx;
    logic block_out;
    logic lunge_out;
    logic release_out;
    logic valid_out;
    logic frame_error_out;

    int n_tests = 0;
    int n_fail  = 0;
    int n_valid = 0;
    int n_err   = 0;
    int both_hi = 0;

    ir_saber_decoder #(.UNIT_CYCLES(UNIT)) dut (
        .clk_pixel_in    (clk),
        .rst_n_in        (rst_n),
        .ir_rx_in        (ir_rx),
        .block_out       (block_out),
        .lunge_out       (lunge_out),
        .release_out     (release_out),
        .valid_out       (valid_out),
        .frame_error_out (frame_error_out)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (valid_out)
            n_valid++;
        if (frame_error_out)
            n_err++;
        if (valid_out && frame_error_out)
            both_hi++;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input int n);
        ir_rx = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_leader(input int g);
        if (g == 0) begin
            drive(1'b1, 4 * UNIT);
        end else begin
            drive(1'b1, 20);
            drive(1'b0, g);
            drive(1'b1, 4 * UNIT - 20 - g);
        end
        drive(1'b0, 2 * UNIT);
    endtask

    task automatic send_mark(input logic b);
        drive(1'b1, b ? 2 * UNIT : UNIT);
    endtask

    task automatic send_frame(input logic b0, input logic b1,
                              input logic b2, input logic p,
                              input int g);
        send_leader(g);
        send_mark(b0);
        drive(1'b0, UNIT);
        send_mark(b1);
        drive(1'b0, UNIT);
        send_mark(b2);
        drive(1'b0, UNIT);
        send_mark(p);
        ir_rx = 1'b0;
    endtask

    // Cycle index (1-based) of the first valid/error after the last
    // raw edge; levels captured in the valid cycle.
    task automatic watch(input int n, output int v_at, output int e_at,
                         output logic [2:0] lv);
        v_at = 0;
        e_at = 0;
        lv   = 3'bxxx;
        for (int i = 1; i <= n; i++) begin
            @(posedge clk);
            #1;
            if (valid_out && v_at == 0) begin
                v_at = i;
                lv   = {block_out, lunge_out, release_out};
            end
            if (frame_error_out && e_at == 0)
                e_at = i;
        end
    endtask

    initial begin
        int va;
        int ea;
        int bv;
        int be;
        logic [2:0] lv;

        ir_rx = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_block", block_out, 0);
        chk("rst_lunge", lunge_out, 0);
        chk("rst_release", release_out, 0);
        chk("rst_valid", valid_out, 0);
        chk("rst_error", frame_error_out, 0);
        rst_n = 1'b1;
        drive(1'b0, 60);

        bv = n_valid;
        be = n_err;
        send_frame(1'b0, 1'b1, 1'b0, 1'b0, 0);
        watch(12, va, ea, lv);
        chk("lunge_valid_at", va, 8);
        chk("lunge_levels", lv, 3'b010);
        chk("lunge_nvalid", n_valid - bv, 1);
        chk("lunge_nerr", n_err - be, 0);
        drive(1'b0, 20);

        bv = n_valid;
        send_frame(1'b0, 1'b1, 1'b0, 1'b1, 0);
        watch(12, va, ea, lv);
        chk("badpar_err_at", ea, 8);
        chk("badpar_nvalid", n_valid - bv, 0);
        chk("badpar_levels", {block_out, lunge_out, release_out}, 3'b010);
        drive(1'b0, 20);

        bv = n_valid;
        send_frame(1'b1, 1'b1, 1'b0, 1'b1, 0);
        watch(12, va, ea, lv);
        chk("excl_err_at", ea, 8);
        chk("excl_nvalid", n_valid - bv, 0);
        chk("excl_levels", {block_out, lunge_out, release_out}, 3'b010);
        drive(1'b0, 20);

        be = n_err;
        send_frame(1'b1, 1'b0, 1'b0, 1'b0, 2);
        watch(12, va, ea, lv);
        chk("glitch2_valid_at", va, 8);
        chk("glitch2_levels", lv, 3'b100);
        chk("glitch2_nerr", n_err - be, 0);
        drive(1'b0, 20);

        bv = n_valid;
        be = n_err;
        send_frame(1'b0, 1'b0, 1'b0, 1'b1, 3);
        watch(12, va, ea, lv);
        drive(1'b0, 60);
        chk("glitch3_nerr", n_err - be, 1);
        chk("glitch3_nvalid", n_valid - bv, 0);
        chk("glitch3_levels", {block_out, lunge_out, release_out}, 3'b100);

        // Space timeout: 6 filter cycles + count of 40 + output register.
        bv = n_valid;
        be = n_err;
        send_leader(0);
        send_mark(1'b0);
        drive(1'b0, UNIT);
        send_mark(1'b1);
        ir_rx = 1'b0;
        watch(60, va, ea, lv);
        chk("timeout_err_at", ea, 47);
        chk("timeout_nerr", n_err - be, 1);
        chk("timeout_nvalid", n_valid - bv, 0);
        drive(1'b0, 20);

        send_frame(1'b0, 1'b0, 1'b1, 1'b0, 0);
        watch(12, va, ea, lv);
        chk("release_valid_at", va, 8);
        chk("release_levels", lv, 3'b001);
        drive(1'b0, 20);

        send_frame(1'b1, 1'b0, 1'b0, 1'b0, 0);
        watch(12, va, ea, lv);
        chk("block_valid_at", va, 8);
        chk("block_levels", lv, 3'b100);

        bv = n_valid;
        be = n_err;
        send_leader(0);
        send_mark(1'b1);
        drive(1'b0, 9);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_block", block_out, 0);
        chk("arst_valid", valid_out, 0);
        chk("arst_error", frame_error_out, 0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b0, 60);
        chk("arst_nvalid", n_valid - bv, 0);
        chk("arst_nerr", n_err - be, 0);

        send_frame(1'b0, 1'b0, 1'b0, 1'b1, 0);
        watch(12, va, ea, lv);
        chk("neutral_valid_at", va, 8);
        chk("neutral_levels", lv, 3'b000);
        chk("neutral_err_at", ea, 0);

        chk("exclusive", both_hi, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ir_saber_decoder.md
Name: ir_saber_decoder

Overview:
- Decodes the pulse-width IR frame sent by a saber handle into block / lunge / release commands plus a one-cycle valid strobe.
- Sits directly upstream of the player action state machine, which samples the three command levels on valid_out.
- Contains an input synchronizer and glitch filter, a pulse-length classifier FSM, and parity and exclusivity checking.

Parameters:
- UNIT_CYCLES, 44550, protocol unit in clk_pixel_in cycles (600 us at 74.25 MHz). Must be even and ≥8. H = UNIT_CYCLES/2.
- CNT_W, $clog2(10*H+1), width of the pulse-length counter (derived localparam).

Ports:
- clk_pixel_in  input  1  pixel clock, the only clock.
- rst_n_in  input  1  asynchronous, active-low reset.
- ir_rx_in  input  1  raw, asynchronous demodulated IR line; 1 = mark (carrier present).
- block_out  output  1  block bit of the last accepted frame (held).
- lunge_out  output  1  lunge bit of the last accepted frame (held).
- release_out  output  1  release bit of the last accepted frame (held).
- valid_out  output  1  one-cycle pulse: a frame was accepted this cycle.
- frame_error_out  output  1  one-cycle pulse: a frame was rejected.

Behaviour:
- Reset:
  - All outputs go to 0 asynchronously.
  - FSM enters RESYNC; counter, synchronizer and filter clear to 0.
  - Reset asserted mid-frame discards the frame with no valid and no error.
- Input path:
  - 2-flop synchronizer feeds s, which shifts into a 3-bit history h.
  - ir_f is registered: it becomes 1 when h==111 and 0 when h==000; otherwise it holds.
  - Raw pulses of 2 cycles or fewer are rejected.
  - Latency from a raw edge to the ir_f edge is 6 cycles.
- Counter:
  - Counts cycles since the last ir_f edge; it is 1 on the first cycle after an edge.
  - Saturates at 10H.
  - L is the counter value at the ir_f edge.
- Classification:
  - Marks: zero H≤L<3H, one 3H≤L<5H, leader 6H≤L<10H.
  - Spaces: bit space H≤L<3H, leader space 3H≤L<5H.
  - Any other L is an error.
- Frame format:
  - Leader mark (4U), then leader space (2U).
  - Then 4 marks with bit spaces (1U) between them: b0=block, b1=lunge, b2=release, b3=parity.
  - A zero mark is 1U and a one mark is 2U.
  - No trailing space is needed.
- States:
  - RESYNC → IDLE once ir_f has been 0 for 6H consecutive cycles. Any mark restarts the wait.
  - IDLE → LEADER on ir_f rising.
  - LEADER → LEADER_SPACE on ir_f falling with a valid leader mark.
  - LEADER_SPACE → BIT_MARK on ir_f rising with a valid leader space.
  - BIT_MARK: on ir_f falling, shift the classified bit in.
    - After the 4th bit, go to CHECK.
    - Otherwise go to BIT_SPACE.
  - BIT_SPACE → BIT_MARK on ir_f rising with a valid bit space.
  - CHECK: evaluate the frame for one cycle, then go to IDLE.
- CHECK evaluation:
  - Accept when b3 == ~(b0^b1^b2) (odd parity over 4 bits) and at most one of b0..b2 is set.
  - Frame 000 with parity 1 is a valid neutral frame.
  - Accept: register the three levels and pulse valid_out.
  - Otherwise: pulse frame_error_out and leave the levels unchanged.
- Latency: valid_out is high exactly 8 cycles after the raw falling edge of the bit-3 mark. The level outputs update in the same cycle.
- Errors:
  - Covers misclassified L, a mark counter reaching 10H, and a mid-frame space counter reaching 5H.
  - The space timeout fires immediately when the counter hits 5H; no edge is needed.
  - Action: pulse frame_error_out for one cycle, go to RESYNC, leave levels unchanged.
- Exclusivity: valid_out and frame_error_out are never high in the same cycle.
- Idle line: ir_f low in IDLE has no timeout.

Decomposition:
- Package ir_pkg:
  - State enum: RESYNC, IDLE, LEADER, LEADER_SPACE, BIT_MARK, BIT_SPACE, CHECK.
  - Bit index constants: BLOCK_BIT=0, LUNGE_BIT=1, RELEASE_BIT=2, PARITY_BIT=3.
  - FRAME_BITS=4.
  - Half-unit multiples for the thresholds: 1, 3, 5, 6, 10.
- Sub-module ir_input_filter: synchronizer plus 3-sample glitch filter, outputs ir_f.

Test Plan (UNIT_CYCLES=16, so H=8; a leader is 64 mark + 32 space, a zero mark is 16, a one mark is 32, a bit space is 16):
- Reset, 60 idle cycles, then a lunge frame (0,1,0, p=0) → valid_out single pulse 8 cycles after the raw end of the last mark; lunge_out=1, block_out=0, release_out=0; frame_error_out stays 0.
- Same frame with parity 1 → frame_error_out pulse, valid_out 0, outputs keep the previous values (lunge_out=1).
- Frame 1,1,0 with p=1 (parity correct, not exclusive) → frame_error_out pulse, outputs unchanged.
- A 2-cycle raw low glitch inside the leader mark → frame decodes normally. A 3-cycle glitch → frame_error_out, then RESYNC.
- A 40-cycle space between b1 and b2 → frame_error_out exactly at count 40. The next frame, sent after ≥48 idle cycles, is accepted.
- rst_n_in pulsed low during BIT_SPACE, 2 cycles after an accepted block frame → block_out drops to 0 asynchronously with no pulses. A neutral frame after ≥48 idle cycles → valid_out pulse with all levels 0.
